// File: rtl/alu_nibble_seq.sv
// alu_nibble_seq: nibble-serial add/sub/slt/sltu sequencer driving one shared 4-bit invert-mux + adder slice
module alu_nibble_seq #(
  parameter int WIDTH = 16,
  parameter int NIB = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);
  localparam int N = WIDTH / NIB;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, nstate;
  logic [WIDTH-1:0] a_r, b_r, raw, bm, nraw, nres;
  logic [1:0] op_r;
  logic [CW-1:0] cnt;
  logic c, c_out, last, nov;
  logic [NIB-1:0] s;
  assign bm = (op_r == 2'b00) ? b_r : ~b_r;
  assign last = cnt == CW'(N - 1);
  assign {c_out, s} = (NIB+1)'(a_r[cnt*NIB +: NIB]) + (NIB+1)'(bm[cnt*NIB +: NIB]) + (NIB+1)'(c);
  assign busy = state != IDLE;
  assign done = state == DONE;
  // nraw is the raw sum with the current nibble merged in, so the last nibble's flags are ready at DONE entry
  always_comb begin
    nraw = raw;
    nraw[cnt*NIB +: NIB] = s;
    nov = (a_r[WIDTH-1] == bm[WIDTH-1]) & (nraw[WIDTH-1] != a_r[WIDTH-1]);
    nres = op_r[1] ? {{(WIDTH-1){1'b0}}, op_r[0] ? ~c_out : nraw[WIDTH-1] ^ nov} : nraw;
  end
  always_comb begin
    nstate = IDLE;
    if (state == IDLE && start) nstate = RUN;
    if (state == RUN) nstate = last ? DONE : RUN;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : nstate;
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      op_r <= '0;
      raw <= '0;
      cnt <= '0;
      c <= 1'b0;
      result <= '0;
      carry <= 1'b0;
      overflow <= 1'b0;
      zero <= 1'b0;
    end else if (state == IDLE && start) begin
      a_r <= a;
      b_r <= b;
      op_r <= op;
      cnt <= '0;
      c <= op != 2'b00;
    end else if (state == RUN) begin
      raw <= nraw;
      c <= c_out;
      cnt <= cnt + CW'(1);
      if (last) begin
        result <= nres;
        carry <= c_out;
        overflow <= nov;
        zero <= nraw == '0;
      end
    end
  end
endmodule

// File: tb/tb_alu_nibble_seq.sv
// tb_alu_nibble_seq: directed and random checks of alu_nibble_seq against an arithmetic reference model
module tb_alu_nibble_seq;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [1:0] op = '0;
  logic [15:0] a = '0, b = '0;
  logic busy, done, carry, overflow, zero;
  logic [15:0] result;
  int checks = 0, errors = 0;
  logic [15:0] last_res = '0;
  alu_nibble_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .carry(carry),
    .overflow(overflow), .zero(zero)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic void model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                                output logic [15:0] res, output logic cy, output logic ov, output logic z);
    int sx, sy, sr;
    logic [16:0] u;
    logic [15:0] r;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (o == 2'b00) begin
      u = {1'b0, x} + {1'b0, y};
      r = u[15:0];
      cy = u[16];
      sr = sx + sy;
    end else begin
      r = x - y;
      cy = x >= y;
      sr = sx - sy;
    end
    ov = sr > 32767 || sr < -32768;
    z = r == 16'h0000;
    res = o == 2'b00 || o == 2'b01 ? r : o == 2'b10 ? {15'b0, sx < sy} : {15'b0, x < y};
  endfunction
  task automatic run_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
    logic [15:0] er;
    logic ec, eo, ez;
    model(o, x, y, er, ec, eo, ez);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = 16'($urandom); b = 16'($urandom); op = 2'($urandom);
    check("busy_accept", busy, 16'd1);
    check("done_accept", done, 16'd0);
    for (int k = 1; k < 4; k++) begin
      @(posedge clk); #1;
      check("busy_run", busy, 16'd1);
      check("done_run", done, 16'd0);
      check("result_hold_run", result, last_res);
    end
    @(posedge clk); #1;
    check("done_pulse", done, 16'd1);
    check("busy_done", busy, 16'd1);
    check("result", result, er);
    check("carry", carry, 16'(ec));
    check("overflow", overflow, 16'(eo));
    check("zero", zero, 16'(ez));
    @(posedge clk); #1;
    check("done_end", done, 16'd0);
    check("busy_end", busy, 16'd0);
    check("result_hold", result, er);
    last_res = er;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_busy", busy, 16'd0);
    check("rst_done", done, 16'd0);
    check("rst_result", result, 16'd0);
    check("rst_carry", carry, 16'd0);
    check("rst_overflow", overflow, 16'd0);
    check("rst_zero", zero, 16'd0);
    run_op(2'b00, 16'h1234, 16'h0FFF);
    check("plan_add", result, 16'h2233);
    run_op(2'b01, 16'h0005, 16'h0007);
    check("plan_sub", result, 16'hFFFE);
    run_op(2'b01, 16'hABCD, 16'hABCD);
    check("plan_sub_zero", zero, 16'd1);
    run_op(2'b00, 16'h7FFF, 16'h0001);
    check("plan_add_ovf", overflow, 16'd1);
    run_op(2'b10, 16'h8000, 16'h0001);
    check("plan_slt", result, 16'h0001);
    run_op(2'b11, 16'h8000, 16'h0001);
    check("plan_sltu", result, 16'h0000);
    check("plan_sltu_carry", carry, 16'd1);
    run_op(2'b01, 16'h8000, 16'h0001);
    run_op(2'b00, 16'hFFFF, 16'h0001);
    run_op(2'b10, 16'h7FFF, 16'h8000);
    run_op(2'b11, 16'h0000, 16'hFFFF);
    for (int i = 0; i < 40; i++) run_op(2'($urandom), 16'($urandom), 16'($urandom));
    // second start during RUN must be dropped, not queued
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 16'h1111; b = 16'h2222;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; op = 2'b01; a = 16'h0F0F; b = 16'h0101;
    @(posedge clk); #1;
    start = 1'b0;
    check("ign_busy", busy, 16'd1);
    @(posedge clk); #1;
    check("ign_done_early", done, 16'd0);
    @(posedge clk); #1;
    check("ign_done", done, 16'd1);
    check("ign_result", result, 16'h3333);
    @(posedge clk); #1;
    check("ign_busy_end", busy, 16'd0);
    @(posedge clk); #1;
    check("ign_not_queued", busy, 16'd0);
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 16'h5555; b = 16'h1111;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", busy, 16'd0);
    check("abort_result", result, 16'h0000);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("abort_no_done", done, 16'd0);
      check("abort_idle", busy, 16'd0);
    end
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check("rst_over_start", busy, 16'd0);
    last_res = 16'h0000;
    run_op(2'b01, 16'h0003, 16'h0003);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
